line_fill_engine: RTL and testbench

- Memory-side counterpart of the cache way.
- On a miss it optionally writes back the dirty victim line to memory, one word per beat.
- It then fetches the new line word by word and assembles it into fetched_line.
- Finally it pulses a one-hot allocate toward the selected way, together with line_address.
- Sits between the cache controller (miss/victim info) and the word-wide memory port.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/line_buffer.sv | 40 ++++
 rtl/line_fill_engine.sv | 144 ++++++++++++++
 tb/tb_line_fill_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache constants and the line-fill state encoding.
// Derived geometry is exposed as constant functions so parameterised modules can size their ports.
package cache_pkg;

  function automatic int words_per_block(input int block_size, input int data_width);
    return block_size / (data_width / 8);
  endfunction

  function automatic int offset_width(input int block_size, input int data_width);
    return $clog2(words_per_block(block_size, data_width));
  endfunction

  function automatic int tag_width(input int address_width, input int block_size,
                                   input int data_width);
    return address_width - offset_width(block_size, data_width);
  endfunction

  function automatic int line_width(input int block_size, input int data_width);
    return words_per_block(block_size, data_width) * data_width;
  endfunction

  typedef enum logic [1:0] {IDLE, WB, FILL, ALLOC} fill_state_e;

endpackage

// File: rtl/line_buffer.sv
// Line storage for the fill engine: latched victim line (word-indexed read for writeback)
// and the line being assembled from memory (word-indexed write during fill).
module line_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int OFFSET_WIDTH   = $clog2(WORDS_PER_BLOCK),
  localparam int LINE_WIDTH     = WORDS_PER_BLOCK * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [LINE_WIDTH-1:0]   victim_line,
  input  logic [OFFSET_WIDTH-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    wr_en,
  input  logic [OFFSET_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [LINE_WIDTH-1:0]   fetched_line
);

  logic [WORDS_PER_BLOCK-1:0][DATA_WIDTH-1:0] victim_q;
  logic [WORDS_PER_BLOCK-1:0][DATA_WIDTH-1:0] fetched_q;

  // Victim data only matters after a load, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) victim_q <= victim_line;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetched_q <= '0;
    end else if (wr_en) begin
      fetched_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data      = victim_q[rd_idx];
  assign fetched_line = fetched_q;

endmodule

// File: rtl/line_fill_engine.sv
// Miss handler: optional dirty-victim writeback, word-by-word line fill, then one-cycle allocate.
// Build option LINE_FILL_CRIT_WORD_FIRST_EN starts the fill at the missing word and wraps.
module line_fill_engine
  import cache_pkg::*;
#(
  parameter int NUM_WAYS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  miss_req,
  input  logic [ADDRESS_WIDTH-1:0]                              miss_addr,
  input  logic [$clog2(NUM_WAYS)-1:0]                           victim_way,
  input  logic                                                  victim_dirty,
  input  logic [tag_width(ADDRESS_WIDTH, BLOCK_SIZE, DATA_WIDTH)-1:0] victim_tag,
  input  logic [line_width(BLOCK_SIZE, DATA_WIDTH)-1:0]         victim_line,
  output logic                                                  busy,
  output logic                                                  done,
  output logic [NUM_WAYS-1:0]                                   allocate,
  output logic [ADDRESS_WIDTH-1:0]                              line_address,
  output logic [line_width(BLOCK_SIZE, DATA_WIDTH)-1:0]         fetched_line,
  output logic                                                  mem_req,
  output logic                                                  mem_we,
  output logic [ADDRESS_WIDTH-1:0]                              mem_addr,
  output logic [DATA_WIDTH-1:0]                                 mem_wdata,
  input  logic                                                  mem_ack,
  input  logic [DATA_WIDTH-1:0]                                 mem_rdata
);

  localparam int WORDS_PER_BLOCK = words_per_block(BLOCK_SIZE, DATA_WIDTH);
  localparam int OFFSET_WIDTH    = offset_width(BLOCK_SIZE, DATA_WIDTH);
  localparam int TAG_WIDTH       = tag_width(ADDRESS_WIDTH, BLOCK_SIZE, DATA_WIDTH);
  localparam int WAY_WIDTH       = $clog2(NUM_WAYS);
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(WORDS_PER_BLOCK - 1);

  fill_state_e             state, state_n;
  logic [OFFSET_WIDTH-1:0] cnt;
  logic [OFFSET_WIDTH-1:0] fill_idx;
  logic [TAG_WIDTH-1:0]    miss_tag;
  logic [TAG_WIDTH-1:0]    wb_tag;
  logic [WAY_WIDTH-1:0]    way;
  logic [DATA_WIDTH-1:0]   wb_word;
  logic                    accept;
  logic                    beat_done;

  assign accept    = (state == IDLE) && miss_req;
  assign beat_done = mem_req && mem_ack;

`ifdef LINE_FILL_CRIT_WORD_FIRST_EN
  logic [OFFSET_WIDTH-1:0] start_off;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_off <= '0;
    end else if (accept) begin
      start_off <= miss_addr[OFFSET_WIDTH-1:0];
    end
  end

  // Offset width equals the counter width, so the sum wraps modulo the line length.
  assign fill_idx = cnt + start_off;
`else
  logic unused_miss_offset;

  assign unused_miss_offset = ^miss_addr[OFFSET_WIDTH-1:0];
  assign fill_idx           = cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      miss_tag <= '0;
      wb_tag   <= '0;
      way      <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        miss_tag <= miss_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
        wb_tag   <= victim_tag;
        way      <= victim_way;
        cnt      <= '0;
      end else if (beat_done) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (miss_req) state_n = victim_dirty ? WB : FILL;
      WB:      if (beat_done && cnt == LAST_WORD) state_n = FILL;
      FILL:    if (beat_done && cnt == LAST_WORD) state_n = ALLOC;
      ALLOC:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == ALLOC);
    allocate  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_tag, cnt};
        mem_wdata = wb_word;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag, fill_idx};
      end
      ALLOC:   allocate[way] = 1'b1;
      default: ;
    endcase
  end

  assign line_address = {miss_tag, {OFFSET_WIDTH{1'b0}}};

  line_buffer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_line_buffer (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (accept),
    .victim_line  (victim_line),
    .rd_idx       (cnt),
    .rd_data      (wb_word),
    .wr_en        ((state == FILL) && beat_done),
    .wr_idx       (fill_idx),
    .wr_data      (mem_rdata),
    .fetched_line (fetched_line)
  );

endmodule

// File: tb/tb_line_fill_engine.sv
// Self-checking bench for line_fill_engine: directed and random misses against a beat-list model.
// Honours LINE_FILL_CRIT_WORD_FIRST_EN when building the expected fill order.
module tb_line_fill_engine;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WPB = 8;
  localparam int OW  = 3;
  localparam int TW  = AW - OW;
  localparam int LW  = WPB * DW;

  logic          clk;
  logic          reset_n;
  logic          miss_req;
  logic [AW-1:0] miss_addr;
  logic [1:0]    victim_way;
  logic          victim_dirty;
  logic [TW-1:0] victim_tag;
  logic [LW-1:0] victim_line;
  logic          busy;
  logic          done;
  logic [3:0]    allocate;
  logic [AW-1:0] line_address;
  logic [LW-1:0] fetched_line;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  line_fill_engine dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .victim_way   (victim_way),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_line  (victim_line),
    .busy         (busy),
    .done         (done),
    .allocate     (allocate),
    .line_address (line_address),
    .fetched_line (fetched_line),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ack_mode: 0 = always ack, 1 = ack every 3rd cycle, 2 = random ack.
  // exp_lat < 0 skips the latency check; poke_at/rst_at of 0 disable those events.
  task automatic run_miss(input logic [AW-1:0] addr, input int wy, input bit dirty,
                          input logic [TW-1:0] vt, input logic [LW-1:0] vl,
                          input logic [DW-1:0] rbase, input int ack_mode, input int exp_lat,
                          input int poke_at, input int rst_at);
    bit            exp_we [16];
    logic [AW-1:0] exp_ad [16];
    logic [DW-1:0] exp_wd [16];
    logic [LW-1:0] exp_line;
    logic [TW-1:0] mtag;
    logic [DW-1:0] rd;
    int nb, p, c, start, idx;
    bit ack, fin;

    mtag = addr[AW-1:OW];
`ifdef LINE_FILL_CRIT_WORD_FIRST_EN
    start = int'(addr[OW-1:0]);
`else
    start = 0;
`endif
    nb = 0;
    if (dirty) begin
      for (int i = 0; i < WPB; i++) begin
        exp_we[nb] = 1'b1;
        exp_ad[nb] = {vt, i[OW-1:0]};
        exp_wd[nb] = vl[i*DW +: DW];
        nb++;
      end
    end
    for (int k = 0; k < WPB; k++) begin
      idx = (start + k) % WPB;
      exp_we[nb] = 1'b0;
      exp_ad[nb] = {mtag, idx[OW-1:0]};
      exp_wd[nb] = '0;
      nb++;
    end
    exp_line = fetched_line;

    miss_addr    = addr;
    victim_way   = wy[1:0];
    victim_dirty = dirty;
    victim_tag   = vt;
    victim_line  = vl;
    miss_req     = 1'b1;
    mem_ack      = 1'($urandom_range(0, 1));
    check("accept_busy", LW'(busy), LW'(0));
    check("accept_mem_req", LW'(mem_req), LW'(0));
    @(posedge clk);
    @(negedge clk);
    miss_req     = 1'b0;
    mem_ack      = 1'b0;
    miss_addr    = $urandom;
    victim_tag   = TW'($urandom);
    victim_line  = {8{$urandom}};
    victim_dirty = 1'($urandom_range(0, 1));

    p = 0;
    c = 1;
    fin = 0;
    while (!fin) begin
      if (c > 400) begin
        checks++;
        errors++;
        $error("FAIL timeout: no allocate after %0d cycles", c);
        fin = 1;
      end else if (c == rst_at) begin
        reset_n = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst_busy", LW'(busy), LW'(0));
        check("rst_mem_req", LW'(mem_req), LW'(0));
        check("rst_allocate", LW'(allocate), LW'(0));
        check("rst_done", LW'(done), LW'(0));
        check("rst_fetched", fetched_line, LW'(0));
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
          mem_ack = 1'($urandom_range(0, 1));
          @(posedge clk);
          @(negedge clk);
          check("post_rst_done", LW'(done), LW'(0));
          check("post_rst_busy", LW'(busy), LW'(0));
        end
        mem_ack = 1'b0;
        fin = 1;
      end else if (p < nb) begin
        check("beat_busy", LW'(busy), LW'(1));
        check("beat_mem_req", LW'(mem_req), LW'(1));
        check("beat_mem_we", LW'(mem_we), LW'(exp_we[p]));
        check("beat_mem_addr", LW'(mem_addr), LW'(exp_ad[p]));
        if (exp_we[p]) check("beat_mem_wdata", LW'(mem_wdata), LW'(exp_wd[p]));
        check("beat_allocate", LW'(allocate), LW'(0));
        check("beat_done", LW'(done), LW'(0));
        check("beat_line_addr", LW'(line_address), LW'({mtag, {OW{1'b0}}}));
        case (ack_mode)
          0:       ack = 1'b1;
          1:       ack = (c % 3 == 0);
          default: ack = 1'($urandom_range(0, 1));
        endcase
        idx = int'(exp_ad[p][OW-1:0]);
        rd  = exp_we[p] ? DW'($urandom) : rbase + DW'(idx);
        mem_ack   = ack;
        mem_rdata = rd;
        if (c == poke_at) begin
          miss_req     = 1'b1;
          miss_addr    = $urandom;
          victim_dirty = 1'b1;
        end
        @(posedge clk);
        if (ack) begin
          if (!exp_we[p]) exp_line[idx*DW +: DW] = rd;
          p++;
        end
        @(negedge clk);
        mem_ack  = 1'b0;
        miss_req = 1'b0;
        c++;
      end else begin
        check("alloc_onehot", LW'(allocate), LW'(4'b0001 << wy));
        check("alloc_done", LW'(done), LW'(1));
        check("alloc_mem_req", LW'(mem_req), LW'(0));
        check("alloc_line_addr", LW'(line_address), LW'({mtag, {OW{1'b0}}}));
        check("alloc_fetched", fetched_line, exp_line);
        if (exp_lat >= 0) check("alloc_latency", LW'(c), LW'(exp_lat));
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("after_busy", LW'(busy), LW'(0));
        check("after_done", LW'(done), LW'(0));
        check("after_allocate", LW'(allocate), LW'(0));
        check("after_mem_req", LW'(mem_req), LW'(0));
        fin = 1;
      end
    end
  endtask

  logic [LW-1:0] dline;

  initial begin
    reset_n      = 1'b0;
    miss_req     = 1'b0;
    miss_addr    = '0;
    victim_way   = '0;
    victim_dirty = 1'b0;
    victim_tag   = '0;
    victim_line  = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", LW'(busy), LW'(0));
    check("reset_done", LW'(done), LW'(0));
    check("reset_allocate", LW'(allocate), LW'(0));
    check("reset_mem_req", LW'(mem_req), LW'(0));
    check("reset_mem_we", LW'(mem_we), LW'(0));
    check("reset_mem_addr", LW'(mem_addr), LW'(0));
    check("reset_mem_wdata", LW'(mem_wdata), LW'(0));
    check("reset_line_addr", LW'(line_address), LW'(0));
    check("reset_fetched", fetched_line, LW'(0));
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < WPB; i++) dline[i*DW +: DW] = DW'(32'hD0 + i);

    // Clean miss, dirty miss, then backpressured clean miss.
    run_miss(32'h0000_0013, 2, 1'b0, TW'(9), {8{$urandom}}, 32'hA0, 0, 9, 0, 0);
    run_miss(32'h0000_0041, 1, 1'b1, TW'(5), dline, 32'hA0, 0, 17, 0, 0);
    run_miss(32'h0000_0100, 3, 1'b0, TW'(0), dline, 32'hA0, 1, 25, 0, 0);

    // Request while busy is ignored; the next one is accepted right after ALLOC.
    run_miss(32'h0000_0200, 0, 1'b0, TW'(0), dline, 32'hB0, 0, 9, 3, 0);
    run_miss(32'h0000_0308, 1, 1'b1, TW'(7), dline, 32'hC0, 0, 17, 0, 0);

    // Reset during the fourth fill beat.
    run_miss(32'h0000_0400, 2, 1'b0, TW'(0), dline, 32'hA0, 0, -1, 0, 4);

    // Offset 6: critical-word order when that build option is on, ascending otherwise.
    run_miss(32'h0000_0016, 0, 1'b0, TW'(0), dline, 32'hA0, 0, 9, 0, 0);

    for (int t = 0; t < 8; t++) begin
      run_miss($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), TW'($urandom),
               {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               $urandom, 2, -1, int'($urandom_range(0, 6)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
